// File: rtl/regfile_scoreboard_if.sv
// Issue/read/writeback bundle between decode-issue, writeback and the register file.
// The register file takes the slave side.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   readReg;
    logic [NREAD*XLEN-1:0] readData;
    logic                  RegWrite;
    logic [AW-1:0]         writeReg;
    logic [XLEN-1:0]       writeData;
    logic                  issueValid;
    logic [AW-1:0]         issueRd;
    logic [NREAD-1:0]      issueSrcMask;
    logic                  stall;
    logic [NREGS-1:0]      busy;

    modport master (
        output readReg, RegWrite, writeReg, writeData, issueValid, issueRd, issueSrcMask,
        input  readData, stall, busy
    );

    modport slave (
        input  readReg, RegWrite, writeReg, writeData, issueValid, issueRd, issueSrcMask,
        output readData, stall, busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with write-to-read bypass and a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards against outstanding writes.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_next;
    logic [NREAD*XLEN-1:0] rdata;
    logic                  wen;
    logic                  raw;
    logic                  waw;
    logic                  stall;
    logic                  accept;
    logic [AW-1:0]         ra;

    // Null addresses (hardwired zero or beyond NREGS) read 0, drop writes, never go busy.
    function automatic logic is_null(input logic [AW-1:0] a);
        return ((ZERO_REG != 0) && (a == '0)) || (int'(a) >= NREGS);
    endfunction

    function automatic logic pending(input logic [AW-1:0] a, input logic wr_en,
                                     input logic [AW-1:0] wr_addr, input logic [NREGS-1:0] b);
        return !is_null(a) && b[a] && !(wr_en && (wr_addr == a));
    endfunction

    assign wen = bus.RegWrite && !is_null(bus.writeReg);

    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = bus.readReg[i*AW +: AW];
            if (reset || is_null(ra))
                rdata[i*XLEN +: XLEN] = '0;
            else if (wen && (bus.writeReg == ra))
                rdata[i*XLEN +: XLEN] = bus.writeData;
            else
                rdata[i*XLEN +: XLEN] = regs[ra];
        end
    end

    always_comb begin
        raw = 1'b0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (bus.issueSrcMask[i] && pending(bus.readReg[i*AW +: AW], wen, bus.writeReg, busy_q))
                raw = 1'b1;
        end
        waw   = pending(bus.issueRd, wen, bus.writeReg, busy_q);
        stall = bus.issueValid && (raw || waw);
    end

    assign accept = bus.issueValid && !stall;

    // Clear first, then set, so an issue and a writeback to the same register leaves it busy.
    always_comb begin
        busy_next = busy_q;
        if (wen)
            busy_next[bus.writeReg] = 1'b0;
        if (accept && !is_null(bus.issueRd))
            busy_next[bus.issueRd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            busy_q <= busy_next;
            if (wen)
                regs[bus.writeReg] <= bus.writeData;
        end
    end

    assign bus.readData = rdata;
    assign bus.stall    = stall;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios on a default and a 3-port/16-register
// instance, plus randomized traffic checked against an array-based reference model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) b0 ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(16), .NREAD(3)) b1 ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) u0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    regfile_scoreboard #(.XLEN(32), .NREGS(16), .NREAD(3), .ZERO_REG(0)) u1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    task automatic drive0(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                          input logic iv, input logic [4:0] rd, input logic [1:0] m,
                          input logic [4:0] a0, input logic [4:0] a1);
        b0.RegWrite = rw; b0.writeReg = wr; b0.writeData = wd;
        b0.issueValid = iv; b0.issueRd = rd; b0.issueSrcMask = m;
        b0.readReg = {a1, a0};
        #1;
    endtask

    task automatic drive1(input logic rw, input logic [3:0] wr, input logic [31:0] wd,
                          input logic iv, input logic [3:0] rd, input logic [2:0] m,
                          input logic [11:0] ra);
        b1.RegWrite = rw; b1.writeReg = wr; b1.writeData = wd;
        b1.issueValid = iv; b1.issueRd = rd; b1.issueSrcMask = m;
        b1.readReg = ra;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, 5'd4, 32'h1111, 1'b1, 5'd4, 2'b11, 5'd4, 5'd4);
        drive1(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 3'b000, 12'h0);
        tests++; if (b0.busy !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", b0.busy); end
        tests++; if (b0.readData !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", b0.readData); end
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", b0.stall); end
        tests++; if (b1.busy !== 16'h0) begin fails++; $display("FAIL reset_busy1: got %h want 0", b1.busy); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 5'd3, 32'd5, 1'b0, 5'd0, 2'b00, 5'd3, 5'd0);
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 2'b00, 5'd3, 5'd3);
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd3, 5'd3);
        tests++; if (b0.busy !== 32'h8) begin fails++; $display("FAIL mid_pre_busy: got %h want 00000008", b0.busy); end
        tests++; if (b0.readData[31:0] !== 32'd5) begin fails++; $display("FAIL mid_pre_x3: got %h want 5", b0.readData[31:0]); end
        drive0(1'b1, 5'd3, 32'd77, 1'b1, 5'd3, 2'b11, 5'd3, 5'd3);
        reset = 1'b1;
        #1;
        tests++; if (b0.busy !== 32'h0) begin fails++; $display("FAIL mid_busy: got %h want 0", b0.busy); end
        tests++; if (b0.readData !== 64'h0) begin fails++; $display("FAIL mid_rdata: got %h want 0", b0.readData); end
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL mid_stall: got %b want 0", b0.stall); end
        tick();
        reset = 1'b0;
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd3, 5'd0);
        tests++; if (b0.readData[31:0] !== 32'h0) begin fails++; $display("FAIL mid_x3_cleared: got %h want 0", b0.readData[31:0]); end
        tick();
    endtask

    task automatic test_bypass();
        drive0(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'b00, 5'd5, 5'd6);
        tests++; if (b0.readData[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_same: got %h want deadbeef", b0.readData[31:0]); end
        tests++; if (b0.readData[63:32] !== 32'h0) begin fails++; $display("FAIL bypass_other: got %h want 0", b0.readData[63:32]); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd5, 5'd5);
        tests++; if (b0.readData !== {32'hDEADBEEF, 32'hDEADBEEF}) begin fails++; $display("FAIL bypass_after: got %h want deadbeefdeadbeef", b0.readData); end
        tick();
    endtask

    task automatic test_zero();
        drive0(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        tests++; if (b0.readData !== 64'h0) begin fails++; $display("FAIL zero_bypass: got %h want 0", b0.readData); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 2'b11, 5'd0, 5'd0);
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %b want 0", b0.stall); end
        tests++; if (b0.readData !== 64'h0) begin fails++; $display("FAIL zero_read: got %h want 0", b0.readData); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 2'b11, 5'd0, 5'd0);
        tests++; if (b0.busy !== 32'h0) begin fails++; $display("FAIL zero_busy: got %h want 0", b0.busy); end
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL zero_stall2: got %b want 0", b0.stall); end
        tick();
    endtask

    task automatic test_raw();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 2'b00, 5'd0, 5'd0);
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL raw_first_issue: got %b want 0", b0.stall); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 2'b01, 5'd7, 5'd0);
        tests++; if (b0.busy !== 32'h80) begin fails++; $display("FAIL raw_busy7: got %h want 00000080", b0.busy); end
        tests++; if (b0.stall !== 1'b1) begin fails++; $display("FAIL raw_stall: got %b want 1", b0.stall); end
        tick();
        drive0(1'b1, 5'd7, 32'hA5, 1'b1, 5'd1, 2'b01, 5'd7, 5'd0);
        tests++; if (b0.busy !== 32'h80) begin fails++; $display("FAIL raw_held: got %h want 00000080", b0.busy); end
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL raw_resolved: got %b want 0", b0.stall); end
        tests++; if (b0.readData[31:0] !== 32'hA5) begin fails++; $display("FAIL raw_bypass: got %h want a5", b0.readData[31:0]); end
        tick();
        drive0(1'b1, 5'd1, 32'h0, 1'b0, 5'd0, 2'b00, 5'd7, 5'd0);
        tests++; if (b0.busy !== 32'h2) begin fails++; $display("FAIL raw_after: got %h want 00000002", b0.busy); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        tests++; if (b0.busy !== 32'h0) begin fails++; $display("FAIL raw_cleared: got %h want 0", b0.busy); end
    endtask

    task automatic test_set_wins();
        drive0(1'b1, 5'd9, 32'd3, 1'b1, 5'd9, 2'b00, 5'd0, 5'd0);
        tests++; if (b0.stall !== 1'b0) begin fails++; $display("FAIL setwins_stall: got %b want 0", b0.stall); end
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 2'b00, 5'd0, 5'd0);
        tests++; if (b0.busy !== 32'h200) begin fails++; $display("FAIL setwins_busy: got %h want 00000200", b0.busy); end
        tests++; if (b0.stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got %b want 1", b0.stall); end
        tick();
        drive0(1'b1, 5'd9, 32'd4, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        tick();
        drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd9, 5'd0);
        tests++; if (b0.busy !== 32'h0 || b0.readData[31:0] !== 32'd4) begin fails++; $display("FAIL setwins_clear: got busy %h x9 %h want 0 / 4", b0.busy, b0.readData[31:0]); end
    endtask

    task automatic test_wide();
        drive1(1'b1, 4'd1, 32'd11, 1'b0, 4'd0, 3'b000, 12'h0);
        tick();
        drive1(1'b1, 4'd2, 32'd22, 1'b0, 4'd0, 3'b000, 12'h0);
        tick();
        drive1(1'b1, 4'd15, 32'hF0F0, 1'b0, 4'd0, 3'b000, {4'd15, 4'd2, 4'd1});
        tests++; if (b1.readData !== {32'hF0F0, 32'd22, 32'd11}) begin fails++; $display("FAIL wide_bypass: got %h want %h", b1.readData, {32'hF0F0, 32'd22, 32'd11}); end
        tick();
        drive1(1'b1, 4'd0, 32'h42, 1'b0, 4'd0, 3'b000, {4'd15, 4'd2, 4'd1});
        tests++; if (b1.readData !== {32'hF0F0, 32'd22, 32'd11}) begin fails++; $display("FAIL wide_read: got %h want %h", b1.readData, {32'hF0F0, 32'd22, 32'd11}); end
        tick();
        drive1(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 3'b000, {4'd0, 4'd0, 4'd0});
        tests++; if (b1.readData[31:0] !== 32'h42) begin fails++; $display("FAIL wide_x0_ordinary: got %h want 42", b1.readData[31:0]); end
        tick();
        drive1(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 3'b100, {4'd15, 4'd2, 4'd1});
        tests++; if (b1.stall !== 1'b1) begin fails++; $display("FAIL wide_port2_stall: got %b want 1", b1.stall); end
        drive1(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 3'b011, {4'd15, 4'd2, 4'd1});
        tests++; if (b1.stall !== 1'b0) begin fails++; $display("FAIL wide_masked: got %b want 0", b1.stall); end
        tick();
        drive1(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 3'b000, 12'h0);
        tests++; if (b1.busy !== 16'h8008) begin fails++; $display("FAIL wide_busy: got %h want 8008", b1.busy); end
    endtask

    // Reference: architectural values and outstanding-write flags as plain arrays.
    task automatic test_random();
        logic [31:0] mregs [32];
        bit          mbusy [32];
        logic        rw, iv, wen, stall_e, hz;
        logic [4:0]  wr, rd, a [2];
        logic [1:0]  m;
        logic [31:0] wd, exp_d;
        logic [31:0] exp_busy;

        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin mregs[r] = '0; mbusy[r] = 1'b0; end
        for (int n = 0; n < 400; n++) begin
            rw = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 15) < 13 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            rd = 5'($urandom_range(0, 7));
            a[0] = 5'($urandom_range(0, 7));
            a[1] = 5'($urandom_range(0, 7));
            m = 2'($urandom);
            wd = $urandom;
            drive0(rw, wr, wd, iv, rd, m, a[0], a[1]);

            wen = rw && (wr != 0);
            hz = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (a[i] == 0) exp_d = '0;
                else if (wen && wr == a[i]) exp_d = wd;
                else exp_d = mregs[a[i]];
                tests++;
                if (b0.readData[i*32 +: 32] !== exp_d) begin
                    fails++; $display("FAIL rand_read%0d cyc %0d: got %h want %h", i, n, b0.readData[i*32 +: 32], exp_d);
                end
                if (m[i] && a[i] != 0 && mbusy[a[i]] && !(wen && wr == a[i])) hz = 1'b1;
            end
            if (rd != 0 && mbusy[rd] && !(wen && wr == rd)) hz = 1'b1;
            stall_e = iv && hz;
            for (int r = 0; r < 32; r++) exp_busy[r] = mbusy[r];
            tests++;
            if (b0.stall !== stall_e) begin fails++; $display("FAIL rand_stall cyc %0d: got %b want %b", n, b0.stall, stall_e); end
            tests++;
            if (b0.busy !== exp_busy) begin fails++; $display("FAIL rand_busy cyc %0d: got %h want %h", n, b0.busy, exp_busy); end

            if (wen) begin mregs[wr] = wd; mbusy[wr] = 1'b0; end
            if (iv && !stall_e && rd != 0) mbusy[rd] = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_bypass();
        test_zero();
        test_raw();
        test_set_wins();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
